// File: rtl/byte_packer.sv
// Packs an 8-bit byte stream into 16-bit words, first byte in the low half.
// A flush pulse pushes out a held odd byte as a masked partial word.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [7:0]  io_in_bits,
  input  logic        io_flush,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [15:0] io_out_bits,
  output logic [1:0]  io_out_mask,
  output logic [7:0]  io_words
);

  logic        lo_valid;
  logic [7:0]  lo_byte;
  logic        out_valid;
  logic [15:0] out_word;
  logic [1:0]  out_mask;
  logic        flush_pend;
  logic [7:0]  words;

  logic in_fire;
  logic out_fire;
  logic load_lo;
  logic pair;
  logic emit;

  // Ready depends only on local state, never on io_out_ready.
  assign io_in_ready = !lo_valid || !out_valid;

  assign in_fire  = io_in_valid && io_in_ready;
  assign out_fire = out_valid && io_out_ready;
  assign load_lo  = in_fire && !lo_valid;
  assign pair     = in_fire && lo_valid;
  assign emit     = (flush_pend || io_flush) && lo_valid
                    && !out_valid && !in_fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_valid   <= 1'b0;
      lo_byte    <= 8'h00;
      out_valid  <= 1'b0;
      out_word   <= 16'h0000;
      out_mask   <= 2'b00;
      flush_pend <= 1'b0;
      words      <= 8'h00;
    end else begin
      if (out_fire) begin
        out_valid <= 1'b0;
        words     <= words + 8'd1;
      end
      if (load_lo) begin
        lo_byte  <= io_in_bits;
        lo_valid <= 1'b1;
        if (io_flush)
          flush_pend <= 1'b1;
      end else if (pair) begin
        out_word   <= {io_in_bits, lo_byte};
        out_mask   <= 2'b11;
        out_valid  <= 1'b1;
        lo_valid   <= 1'b0;
        flush_pend <= 1'b0;
      end else if (emit) begin
        out_word   <= {8'h00, lo_byte};
        out_mask   <= 2'b01;
        out_valid  <= 1'b1;
        lo_valid   <= 1'b0;
        flush_pend <= 1'b0;
      end else if (io_flush && lo_valid) begin
        // Output slot busy: remember the flush until it drains.
        flush_pend <= 1'b1;
      end
    end
  end

  assign io_out_valid = out_valid;
  assign io_out_bits  = out_word;
  assign io_out_mask  = out_mask;
  assign io_words     = words;

endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: directed cases plus a
// randomized run against a queue-based reference model.
module tb_byte_packer;

  logic        clk;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [7:0]  io_in_bits;
  logic        io_flush;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [15:0] io_out_bits;
  logic [1:0]  io_out_mask;
  logic [7:0]  io_words;

  int tests;
  int fails;

  byte_packer dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_bits   (io_in_bits),
    .io_flush     (io_flush),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
    .io_out_mask  (io_out_mask),
    .io_words     (io_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic iv, input logic [7:0] b,
                      input logic fl, input logic ordy);
    io_in_valid  = iv;
    io_in_bits   = b;
    io_flush     = fl;
    io_out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    io_in_valid  = 1'b0;
    io_in_bits   = 8'h00;
    io_flush     = 1'b0;
    io_out_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    io_in_valid  = 1'b0;
    io_in_bits   = 8'h00;
    io_flush     = 1'b0;
    io_out_ready = 1'b0;
    reset = 1'b0;
    #3;
    tests++;
    if ({io_in_ready, io_out_valid, io_out_bits,
         io_out_mask, io_words} !== {1'b1, 1'b0, 16'h0, 2'b0, 8'h0}) begin
      fails++;
      $display("FAIL reset: rdy=%b v=%b bits=%h m=%b w=%h want 1 0 0000 00 00",
               io_in_ready, io_out_valid, io_out_bits, io_out_mask, io_words);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_full_word();
    do_reset();
    step(1'b1, 8'hA1, 1'b0, 1'b1);
    step(1'b1, 8'hB2, 1'b0, 1'b1);
    tests++;
    if ({io_out_valid, io_out_bits, io_out_mask} !== {1'b1, 16'hB2A1, 2'b11}) begin
      fails++;
      $display("FAIL full_word: v=%b bits=%h m=%b want 1 b2a1 11",
               io_out_valid, io_out_bits, io_out_mask);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    tests++;
    if ({io_out_valid, io_words} !== {1'b0, 8'h01}) begin
      fails++;
      $display("FAIL full_word_count: v=%b words=%h want 0 01",
               io_out_valid, io_words);
    end
  endtask

  task automatic test_flush_partial();
    do_reset();
    step(1'b1, 8'h5C, 1'b0, 1'b0);
    tests++;
    if (io_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_early: v=%b want 0", io_out_valid);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if ({io_out_valid, io_out_bits, io_out_mask} !== {1'b1, 16'h005C, 2'b01}) begin
      fails++;
      $display("FAIL flush_partial: v=%b bits=%h m=%b want 1 005c 01",
               io_out_valid, io_out_bits, io_out_mask);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    tests++;
    if ({io_out_valid, io_out_bits, io_out_mask} !== {1'b1, 16'h005C, 2'b01}) begin
      fails++;
      $display("FAIL flush_hold: v=%b bits=%h m=%b want 1 005c 01",
               io_out_valid, io_out_bits, io_out_mask);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    tests++;
    if ({io_out_valid, io_words} !== {1'b0, 8'h01}) begin
      fails++;
      $display("FAIL flush_drain: v=%b words=%h want 0 01",
               io_out_valid, io_words);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    tests++;
    if ({io_in_ready, io_out_valid, io_out_bits} !== {1'b0, 1'b1, 16'h0201}) begin
      fails++;
      $display("FAIL bp_held: rdy=%b v=%b bits=%h want 0 1 0201",
               io_in_ready, io_out_valid, io_out_bits);
    end
    step(1'b1, 8'h04, 1'b0, 1'b0);
    tests++;
    if ({io_in_ready, io_out_bits, io_out_mask} !== {1'b0, 16'h0201, 2'b11}) begin
      fails++;
      $display("FAIL bp_stall: rdy=%b bits=%h m=%b want 0 0201 11",
               io_in_ready, io_out_bits, io_out_mask);
    end
    step(1'b1, 8'h04, 1'b0, 1'b1);
    tests++;
    if ({io_in_ready, io_out_valid, io_words} !== {1'b1, 1'b0, 8'h01}) begin
      fails++;
      $display("FAIL bp_release: rdy=%b v=%b words=%h want 1 0 01",
               io_in_ready, io_out_valid, io_words);
    end
    step(1'b1, 8'h04, 1'b0, 1'b0);
    tests++;
    if ({io_out_valid, io_out_bits, io_out_mask} !== {1'b1, 16'h0403, 2'b11}) begin
      fails++;
      $display("FAIL bp_second: v=%b bits=%h m=%b want 1 0403 11",
               io_out_valid, io_out_bits, io_out_mask);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_flush_coincident();
    do_reset();
    step(1'b1, 8'h66, 1'b0, 1'b1);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    tests++;
    if ({io_out_valid, io_out_bits, io_out_mask} !== {1'b1, 16'h7766, 2'b11}) begin
      fails++;
      $display("FAIL flush_coinc: v=%b bits=%h m=%b want 1 7766 11",
               io_out_valid, io_out_bits, io_out_mask);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    tests++;
    if ({io_out_valid, io_words} !== {1'b0, 8'h01}) begin
      fails++;
      $display("FAIL flush_coinc_extra: v=%b words=%h want 0 01",
               io_out_valid, io_words);
    end
  endtask

  task automatic test_flush_empty_and_wrap();
    int acc;
    int cyc;
    bit seen_ff;
    do_reset();
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    tests++;
    if ({io_out_valid, io_words} !== {1'b0, 8'h00}) begin
      fails++;
      $display("FAIL flush_empty: v=%b words=%h want 0 00",
               io_out_valid, io_words);
    end
    acc = 0;
    cyc = 0;
    seen_ff = 1'b0;
    while (acc < 512 && cyc < 3000) begin
      if (io_in_ready === 1'b1) acc++;
      step(1'b1, 8'($urandom), 1'b0, 1'b1);
      cyc++;
      if (io_words === 8'hFF) seen_ff = 1'b1;
    end
    tests++;
    if (cyc !== 512) begin
      fails++;
      $display("FAIL throughput: cycles=%0d want 512 (accepted %0d)", cyc, acc);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    tests++;
    if ({seen_ff, io_words, io_out_valid} !== {1'b1, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL wrap: seen_ff=%b words=%h v=%b want 1 00 0",
               seen_ff, io_words, io_out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    io_in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if ({io_out_valid, io_in_ready, io_out_bits, io_out_mask}
        !== {1'b0, 1'b1, 16'h0, 2'b00}) begin
      fails++;
      $display("FAIL reset_mid: v=%b rdy=%b bits=%h m=%b want 0 1 0000 00",
               io_out_valid, io_in_ready, io_out_bits, io_out_mask);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    tests++;
    if ({io_out_valid, io_words} !== {1'b0, 8'h00}) begin
      fails++;
      $display("FAIL reset_stale: v=%b words=%h want 0 00",
               io_out_valid, io_words);
    end
  endtask

  task automatic test_random();
    logic [7:0]  held[$];
    logic [17:0] outq[$];
    logic        pend;
    logic [7:0]  mw;
    logic        iv, fl, ordy, rdy, busy;
    logic [7:0]  b;
    int          errs;
    do_reset();
    pend = 1'b0;
    mw = 8'h00;
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      iv   = ($urandom_range(0, 99) < 60);
      fl   = ($urandom_range(0, 99) < 15);
      ordy = ($urandom_range(0, 99) < 65);
      b    = 8'($urandom);
      rdy  = !(held.size() == 1 && outq.size() == 1);
      busy = (outq.size() != 0);
      tests++;
      if (io_in_ready !== rdy || io_out_valid !== busy || io_words !== mw) begin
        fails++;
        errs++;
        if (errs < 10)
          $display("FAIL rand_ctl[%0d]: rdy=%b v=%b w=%h want %b %b %h",
                   i, io_in_ready, io_out_valid, io_words, rdy, busy, mw);
      end
      if (busy) begin
        tests++;
        if ({io_out_mask, io_out_bits} !== outq[0]) begin
          fails++;
          errs++;
          if (errs < 10)
            $display("FAIL rand_data[%0d]: m=%b bits=%h want %h",
                     i, io_out_mask, io_out_bits, outq[0]);
        end
      end
      if (busy && ordy) begin
        void'(outq.pop_front());
        mw = mw + 8'd1;
      end
      if (iv && rdy) begin
        if (held.size() == 0) begin
          held.push_back(b);
          if (fl) pend = 1'b1;
        end else begin
          outq.push_back({2'b11, b, held.pop_front()});
          pend = 1'b0;
        end
      end else if (held.size() == 1 && (pend || fl) && !busy) begin
        outq.push_back({2'b01, 8'h00, held.pop_front()});
        pend = 1'b0;
      end else if (fl && held.size() == 1) begin
        pend = 1'b1;
      end
      step(iv, b, fl, ordy);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    test_reset();
    test_full_word();
    test_flush_partial();
    test_backpressure();
    test_flush_coincident();
    test_flush_empty_and_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
